// File: rtl/inv_mix_columns_seq_if.sv
// Handshake bus for the column-serial (Inv)MixColumns engine.
// MC_SEQ_FWD_EN adds the enc_dec mode select next to in_valid.
interface inv_mix_columns_seq_if;
  logic             in_valid;
`ifdef MC_SEQ_FWD_EN
  logic             enc_dec;
`endif
  logic             in_ready;
  logic [3:0][31:0] state_i;
  logic             out_valid;
  logic             out_ready;
  logic [3:0][31:0] state_o;
  logic             busy;

  // Upstream/downstream side: drives the input state and the output ready.
  modport master (
    output in_valid,
`ifdef MC_SEQ_FWD_EN
    output enc_dec,
`endif
    output state_i, output out_ready,
    input  in_ready, input out_valid, input state_o, input busy
  );

  // Engine side.
  modport slave (
    input  in_valid,
`ifdef MC_SEQ_FWD_EN
    input  enc_dec,
`endif
    input  state_i, input out_ready,
    output in_ready, output out_valid, output state_o, output busy
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// Column-serial InvMixColumns engine: captures a 128-bit state, runs one
// 32-bit column per cycle through a single shared GF(2^8) column unit
// (column 3 first, column 0 last), then holds the result until taken.
// Optional macro MC_SEQ_FWD_EN: adds enc_dec to select forward MixColumns
// per transaction; without it the engine is inverse-only.
module inv_mix_columns_seq #(
  parameter int          NCOL    = 4,
  parameter logic [7:0]  GF_POLY = 8'h1B
) (
  input  logic                 clk,
  input  logic                 rst,
  inv_mix_columns_seq_if.slave bus
);
  localparam int CW = $clog2(NCOL);
  localparam logic [CW-1:0] CNT_TOP = CW'(NCOL - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} st_e;

  st_e                   state_q, state_d;
  logic [NCOL-1:0][31:0] work_q, work_nx;
  logic [NCOL-1:0][31:0] so_q;
  logic [CW-1:0]         cnt_q;
  logic [31:0]           col_cur, col_new;

  // Multiply by x modulo the AES polynomial; 8-bit result, no growth.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction

  // Inverse column: 0E/0B/0D/09 circulant built from x2/x4/x8 chains.
  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

`ifdef MC_SEQ_FWD_EN
  logic mode_q;

  // Forward column: 02/03/01/01 circulant.
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] d2 [4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      d2[i] = xt(a[i]);
    end
    return {d2[0] ^ d2[1] ^ a[1] ^ a[2] ^ a[3],
            a[0] ^ d2[1] ^ d2[2] ^ a[2] ^ a[3],
            a[0] ^ a[1] ^ d2[2] ^ d2[3] ^ a[3],
            d2[0] ^ a[0] ^ a[1] ^ a[2] ^ d2[3]};
  endfunction

  // Shared column unit; mode was latched at the input handshake.
  always_comb col_new = mode_q ? fwd_col(col_cur) : inv_col(col_cur);
`else
  // Shared column unit, inverse only.
  always_comb col_new = inv_col(col_cur);
`endif

  // Working state with the current column replaced by its transform.
  always_comb begin
    col_cur        = work_q[cnt_q];
    work_nx        = work_q;
    work_nx[cnt_q] = col_new;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; no input is accepted in DONE, so IDLE is always revisited.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = BUSY;
      BUSY:    if (cnt_q == '0)   state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the state register only.
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
  end

  assign bus.state_o = so_q;

  // Datapath: capture, column-per-cycle update, result latch on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      work_q <= '0;
      so_q   <= '0;
      cnt_q  <= CNT_TOP;
`ifdef MC_SEQ_FWD_EN
      mode_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          work_q <= bus.state_i;
          cnt_q  <= CNT_TOP;
`ifdef MC_SEQ_FWD_EN
          mode_q <= bus.enc_dec;
`endif
        end
        BUSY: begin
          work_q <= work_nx;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) so_q <= work_nx;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed + back-to-back random bench for inv_mix_columns_seq with a
// queue scoreboard and an independent shift-and-add GF(2^8) model.
module tb_inv_mix_columns_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [127:0] sb [$];

  inv_mix_columns_seq_if bus ();
  inv_mix_columns_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [7:0] k [4] = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    logic [127:0] r = '0;
    logic [7:0] a [4];
    logic [7:0] b;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[32*c + 31 - 8*i -: 8];
      for (int row = 0; row < 4; row++) begin
        b = 8'h00;
        for (int i = 0; i < 4; i++) b = b ^ gmul(k[(i - row + 4) % 4], a[i]);
        r[32*c + 31 - 8*row -: 8] = b;
      end
    end
    return r;
  endfunction

  // Wait for in_ready, present one state for exactly one handshake edge.
  task automatic send(input logic [127:0] st, input logic [127:0] exp);
    int n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_before_send", 128'(bus.in_ready), 128'(1));
    bus.in_valid = 1'b1;
    bus.state_i  = st;
    tick();
    bus.in_valid = 1'b0;
    bus.state_i  = {$urandom, $urandom, $urandom, $urandom};
    sb.push_back(exp);
  endtask

  // Expect out_valid 4 edges after the handshake, hold, then take the result.
  task automatic recv(input int elapsed, input int hold);
    int n = elapsed;
    logic [127:0] exp;
    while (!bus.out_valid && n < 12) begin
      chk("in_ready_low_busy", 128'(bus.in_ready), 128'(0));
      tick();
      n++;
    end
    chk("latency", 128'(n), 128'(4));
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 128'(0), 128'(1));
    end else if (bus.out_valid) begin
      exp = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
        chk("hold_valid", 128'(bus.out_valid), 128'(1));
        chk("hold_data", bus.state_o, exp);
        chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
        tick();
      end
      chk("result", bus.state_o, exp);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("out_valid_drop", 128'(bus.out_valid), 128'(0));
      chk("in_ready_after", 128'(bus.in_ready), 128'(1));
    end else begin
      void'(sb.pop_front());
    end
  endtask

  initial begin
    logic [127:0] v1_in, v1_ex, v2_in, v2_ex, st;
    int sent, got, cyc, last;
    bit hs_in, hs_out;

    v1_in = {32'h8E4DA1BC, 32'hC6C6C6C6, 32'hC6C6C6C6, 32'hC6C6C6C6};
    v1_ex = {32'hDB135345, 32'hC6C6C6C6, 32'hC6C6C6C6, 32'hC6C6C6C6};
    v2_in = {32'h9FDC589D, 32'hD5D5D7D6, 32'h01010101, 32'h4D7EBDF8};
    v2_ex = {32'hF20A225C, 32'hD4D4D4D5, 32'h01010101, 32'h2D26314C};

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.state_i   = '0;
`ifdef MC_SEQ_FWD_EN
    bus.enc_dec   = 1'b0;
`endif
    tick();
    tick();
    chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_state_o", bus.state_o, 128'(0));
    rst = 1'b0;
    tick();

    // Known vector, immediate take.
    send(v1_in, v1_ex);
    chk("busy_after_accept", 128'(bus.busy), 128'(1));
    recv(0, 0);

    // Second known vector, downstream stalls for 10 cycles.
    send(v2_in, v2_ex);
    recv(0, 10);

    // New in_valid during BUSY is ignored.
    send(v2_in, v2_ex);
    bus.in_valid = 1'b1;
    bus.state_i  = v1_in;
    tick();
    tick();
    bus.in_valid = 1'b0;
    recv(2, 0);

    // Reset in the second BUSY cycle aborts the transaction.
    send(v1_in, v1_ex);
    tick();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    void'(sb.pop_back());
    chk("abort_in_ready", 128'(bus.in_ready), 128'(1));
    chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
    chk("abort_busy", 128'(bus.busy), 128'(0));
    chk("abort_state_o", bus.state_o, 128'(0));
    send(v2_in, v2_ex);
    recv(0, 0);

`ifdef MC_SEQ_FWD_EN
    // Forward mode, enc_dec wiggled after the handshake.
    bus.enc_dec = 1'b1;
    send(v1_ex, v1_in);
    bus.enc_dec = 1'b0;
    tick();
    bus.enc_dec = 1'b1;
    recv(1, 0);
    bus.enc_dec = 1'b0;
    send(v1_in, v1_ex);
    bus.enc_dec = 1'b1;
    recv(0, 0);
    bus.enc_dec = 1'b0;
`endif

    // Back-to-back: in_valid and out_ready held high, 100 random states.
    sent = 0; got = 0; cyc = 0; last = -1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.state_i   = {$urandom, $urandom, $urandom, $urandom};
    while (got < 100 && cyc < 2000) begin
      hs_in  = bus.in_valid && bus.in_ready;
      hs_out = bus.out_valid;
      if (hs_in) begin
        sb.push_back(ref_inv(bus.state_i));
        sent++;
      end
      if (hs_out) begin
        if (sb.size() == 0) chk("b2b_sb_nonempty", 128'(0), 128'(1));
        else chk("b2b_data", bus.state_o, sb.pop_front());
        if (last >= 0) chk("b2b_spacing", 128'(cyc - last), 128'(6));
        last = cyc;
        got++;
      end
      tick();
      cyc++;
      if (hs_in) begin
        st = {$urandom, $urandom, $urandom, $urandom};
        bus.state_i = st;
        if (sent == 100) bus.in_valid = 1'b0;
      end
    end
    chk("b2b_count", 128'(got), 128'(100));
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
